// File: rtl/buffer_datos.sv
// ---------------------------------------------------------------------------
// buffer_datos
//   Synchronous FIFO that captures words from the lab data generator and
//   hands them to downstream consumers over a valid/ready stream. It also
//   reports occupancy, almost-full and a sticky overflow flag so that the
//   generator's write rate can be monitored.
//
// Ports
//   clk          system clock; all state updates on the rising edge
//   rst          synchronous reset, active-high
//   wr_en        write request from the generator
//   wr_data      word from the generator
//   rd_ready     consumer accepts rd_data this cycle
//   clr_ovf      clears the sticky overflow flag
//   rd_valid     FIFO holds at least one word
//   rd_data      oldest stored word (first-word fall-through)
//   count        current occupancy, 0..DEPTH
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   overflow     sticky; a write was dropped
// ---------------------------------------------------------------------------
module buffer_datos #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         rd_ready,
  input  logic                         clr_ovf,
  output logic                         rd_valid,
  output logic [WIDTH-1:0]             rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         almost_full,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // Flags come straight from the registered count, so they only move on edges.
  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));
  assign rd_valid    = !empty;
  assign rd_data     = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a write into a full FIFO is
  // still accepted when the consumer drains at the same time.
  assign pop  = rd_valid && rd_ready;
  assign push = wr_en && (!full || pop);

  // Storage: data only, never reset; stale contents are unreachable once
  // the pointers have been cleared.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Control state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      // Setting the flag takes priority over a simultaneous clear.
      if (wr_en && full && !pop) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: doc/buffer_datos.md
Name: buffer_datos

Overview:
- Synchronous FIFO that captures the 16-bit words produced by the lab data generator whenever its write enable is high.
- Presents the captured words to downstream consumers (display/checker) over a valid/ready stream.
- Provides occupancy, almost-full and a sticky overflow flag so the generator's write rate can be monitored.

Parameters:
- WIDTH, 16, data word width; matches the generator output.
- DEPTH, 8, number of storage entries; power of two, >= 2.
- AF_LEVEL, 6, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- wr_en  input  1  write request from generator (its we).
- wr_data  input  WIDTH  word from generator.
- rd_ready  input  1  consumer accepts rd_data this cycle.
- clr_ovf  input  1  clears the sticky overflow flag.
- rd_valid  output  1  FIFO holds at least one word.
- rd_data  output  WIDTH  oldest stored word.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- overflow  output  1  sticky; a write was dropped.

Behaviour:
- Reset: when rst=1 at a clock edge, the following take their reset values:
  - wr_ptr, rd_ptr, count = 0.
  - overflow = 0.
  - empty = 1.
  - rd_valid, full, almost_full = 0.
  - Memory contents need not be cleared.
  - rd_data is don't-care while empty.
  - Reset overrides every other input in the same cycle, including mid-stream; stored words are discarded.
- Pointers: log2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0.
- Push condition: push = wr_en && (!full || pop).
  - Write wr_data to mem[wr_ptr], then increment wr_ptr.
- Pop condition: pop = rd_valid && rd_ready.
  - Increment rd_ptr.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop: unchanged.
  - neither: unchanged.
- Output timing:
  - rd_valid = !empty.
  - rd_data = mem[rd_ptr], combinational read (first-word fall-through).
  - A word written at edge N is visible on rd_data with rd_valid=1 after edge N, i.e. one-cycle write-to-read latency.
  - There is no bypass: writing into an empty FIFO never presents data in the same cycle.
- rd_data/rd_valid stability: while rd_valid=1 and rd_ready=0, rd_data and rd_valid must hold stable.
- Status flags: full, empty and almost_full are derived from the registered count. They change only on clock edges.
- Simultaneous read/write:
  - When full, wr_en=1 and pop=1: the write is accepted, count stays DEPTH, and no overflow is raised.
  - When empty, wr_en=1 and rd_ready=1: only the push occurs, because pop requires rd_valid.
- Overflow:
  - Set at the edge when wr_en && full && !pop; the write is dropped and memory/pointers are unchanged.
  - Cleared by clr_ovf=1.
  - If a set condition and clr_ovf occur in the same cycle, set wins (overflow=1).
- Underflow is impossible by construction. rd_ready with rd_valid=0 has no effect.
- Inputs X when wr_en=0 must not corrupt state. There are no $display or random calls in the RTL.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then wr_en=0 and rd_ready=0 for 5 cycles.
  - Required: count=0, empty=1, rd_valid=0, full=0, overflow=0 throughout.
- Single word latency:
  - Stimulus: wr_en=1 with wr_data=16'hA5A5 for one cycle, rd_ready=0.
  - Required: the cycle after, rd_valid=1, rd_data=16'hA5A5, count=1. Then rd_ready=1 for one cycle gives count=0, empty=1.
- Fill, overflow and order:
  - Stimulus: write 16'h0001..16'h0009 on consecutive cycles with rd_ready=0 (DEPTH=8).
  - Required:
    - almost_full rises after the 6th write.
    - full rises after the 8th write.
    - The 9th write is dropped and overflow=1.
    - Draining returns 0001..0008 in order.
    - count returns to 0.
- Simultaneous push/pop at full:
  - Stimulus: with the FIFO full of 0001..0008, assert wr_en=1 (wr_data=16'h00FF) and rd_ready=1 together for one cycle.
  - Required: count stays 8, overflow stays 0, rd_data becomes 0002. Draining ends with 00FF.
- Wrap-around streaming:
  - Stimulus: 40 cycles of wr_en=1 with incrementing data and rd_ready=1 continuously.
  - Required: output sequence equals input sequence delayed by 1 cycle, count never exceeds 1, overflow=0.
- Overflow clear and reset mid-operation:
  - Stimulus: with overflow=1, assert clr_ovf for one cycle; then, with count=5, assert rst=1 for one cycle.
  - Required: overflow=0 after clr_ovf. After reset, count=0 and empty=1. A following write of 16'h1234 is read back first.
